// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command-master FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } ahb_state_e;

  // A transfer is legal only for byte/half/word sizes on a naturally aligned address.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    return (size == HSIZE_BYTE) ||
           ((size == HSIZE_HALF) && (addr_lsb[0] == 1'b0)) ||
           ((size == HSIZE_WORD) && (addr_lsb == 2'b00));
  endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: turns one valid/ready command into one
// SINGLE transfer and returns the result through a valid/ready response port.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                   hclk_i,
  input  logic                   hrst_n_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [ADDR_BITS+1:0]   cmd_addr_i,
  input  logic [2:0]             cmd_size_i,
  input  logic [3:0]             cmd_strb_i,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [ADDR_BITS+1:0]   haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [3:0]             hprot_o,
  output logic                   hmasterlock_o,
  output logic [3:0]             hstrb_o,
  output logic [DATA_WIDTH-1:0]  hwdata_o,
  input  logic                   hready_i,
  input  logic [DATA_WIDTH-1:0]  hrdata_i,
  input  logic                   hresp_i
);

  ahb_state_e            state_q, state_d;
  logic                  rdy_q;
  logic                  accept;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign accept  = cmd_valid_i && rdy_q;
  assign illegal = !cmd_legal(cmd_size_i, cmd_addr_i[1:0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)      state_d = illegal ? ST_RESP : ST_ADDR;
      ST_ADDR: if (hready_i)    state_d = ST_DATA;
      ST_DATA: if (hready_i)    state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low during reset and
  // rises on the first clock after release, yet is only ever high in IDLE.
  always_ff @(posedge hclk_i or negedge hrst_n_i) begin
    if (!hrst_n_i) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      haddr_o     <= '0;
      hwrite_o    <= 1'b0;
      hsize_o     <= '0;
      hstrb_o     <= '0;
      wdata_q     <= '0;
      hwdata_o    <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      if (accept) begin
        haddr_o  <= cmd_addr_i;
        hwrite_o <= cmd_write_i;
        hsize_o  <= cmd_size_i;
        hstrb_o  <= cmd_strb_i;
        wdata_q  <= cmd_wdata_i;
        if (illegal) begin
          rsp_err_o   <= 1'b1;
          rsp_rdata_o <= '0;
        end
      end
      // Write data only moves when a write enters its data phase.
      if ((state_q == ST_ADDR) && hready_i && hwrite_o)
        hwdata_o <= wdata_q;
      if ((state_q == ST_DATA) && hready_i) begin
        rsp_err_o   <= hresp_i;
        rsp_rdata_o <= (!hwrite_o && !hresp_i) ? hrdata_i : '0;
      end
    end
  end

  assign cmd_ready_o   = rdy_q;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign htrans_o      = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst_o      = HBURST_SINGLE;
  assign hprot_o       = HPROT_VAL;
  assign hmasterlock_o = 1'b0;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Randomized bench for ahb_cmd_master: the bench acts as the AHB slave with a
// word memory and predicts each response from transaction-level rules.
module tb_ahb_cmd_master;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = ADDR_BITS + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [3:0]    cmd_strb;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite, hmasterlock;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot, hstrb;
  logic [DW-1:0] hwdata, hrdata;
  logic          hready, hresp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] last_hwdata;

  ahb_cmd_master #(.ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DW), .HPROT_VAL(4'b0011)) dut (
    .hclk_i(clk), .hrst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_strb_i(cmd_strb),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite), .hsize_o(hsize),
    .hburst_o(hburst), .hprot_o(hprot), .hmasterlock_o(hmasterlock),
    .hstrb_o(hstrb), .hwdata_o(hwdata),
    .hready_i(hready), .hrdata_i(hrdata), .hresp_i(hresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random command traffic while the master is busy must be ignored.
  task automatic scramble_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_size  = 3'($urandom);
    cmd_strb  = 4'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_haddr"},     64'(haddr),     64'd0);
    check({tag, "_htrans"},    64'(htrans),    64'd0);
    check({tag, "_hwrite"},    64'(hwrite),    64'd0);
    check({tag, "_hsize"},     64'(hsize),     64'd0);
    check({tag, "_hstrb"},     64'(hstrb),     64'd0);
    check({tag, "_hwdata"},    64'(hwdata),    64'd0);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      check("idle_htrans",    64'(htrans),    64'd0);
      check("idle_hwdata",    64'(hwdata),    64'(last_hwdata));
      tick();
    end
  endtask

  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [2:0] size,
                         input logic [3:0] strb, input logic [DW-1:0] wdata,
                         input int unsigned wa, input int unsigned wd, input logic err,
                         input int unsigned rdly);
    int unsigned   idx;
    logic          legal;
    logic          exp_err;
    logic [DW-1:0] exp_rdata, word;
    idx   = int'(addr[5:2]);
    legal = (size <= 3'd2) && ((int'(addr) % (1 << int'(size))) == 0);

    check("accept_cmd_ready", 64'(cmd_ready), 64'd1);
    check("hburst", 64'(hburst), 64'd0);
    check("hprot", 64'(hprot), 64'h3);
    check("hmasterlock", 64'(hmasterlock), 64'd0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size;
    cmd_strb = strb; cmd_wdata = wdata; rsp_ready = 1'b0;
    tick();
    scramble_cmd();

    if (!legal) begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      for (int unsigned i = 0; i <= wa; i++) begin
        check("addr_htrans",    64'(htrans),    64'h2);
        check("addr_haddr",     64'(haddr),     64'(addr));
        check("addr_hwrite",    64'(hwrite),    64'(wr));
        check("addr_hsize",     64'(hsize),     64'(size));
        check("addr_hstrb",     64'(hstrb),     64'(strb));
        check("addr_rsp_valid", 64'(rsp_valid), 64'd0);
        check("addr_cmd_ready", 64'(cmd_ready), 64'd0);
        check("addr_hwdata",    64'(hwdata),    64'(last_hwdata));
        hready = (i == wa);
        hresp  = 1'b0;
        hrdata = $urandom;
        tick();
        scramble_cmd();
      end
      if (wr) last_hwdata = wdata;
      for (int unsigned j = 0; j <= wd; j++) begin
        check("data_htrans",    64'(htrans),    64'd0);
        check("data_hwdata",    64'(hwdata),    64'(last_hwdata));
        check("data_rsp_valid", 64'(rsp_valid), 64'd0);
        check("data_cmd_ready", 64'(cmd_ready), 64'd0);
        hready = (j == wd);
        hresp  = err && (j + 1 >= wd);
        hrdata = (j == wd) ? mem[idx] : $urandom;
        tick();
        scramble_cmd();
      end
      exp_err   = err;
      exp_rdata = (!wr && !err) ? mem[idx] : '0;
      if (wr && !err) begin
        word = mem[idx];
        for (int b = 0; b < 4; b++)
          if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
        mem[idx] = word;
      end
    end

    hready = 1'b1;
    hresp  = 1'b0;
    for (int unsigned k = 0; k <= rdly; k++) begin
      check("rsp_valid",     64'(rsp_valid), 64'd1);
      check("rsp_err",       64'(rsp_err),   64'(exp_err));
      check("rsp_rdata",     64'(rsp_rdata), 64'(exp_rdata));
      check("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rsp_htrans",    64'(htrans),    64'd0);
      check("rsp_hwdata",    64'(hwdata),    64'(last_hwdata));
      rsp_ready = (k == rdly);
      tick();
      scramble_cmd();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wr, err;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    int unsigned   wd;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    last_hwdata = '0;
    rst_n = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_strb = '0; cmd_wdata = '0;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("release_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("first_clk_cmd_ready", 64'(cmd_ready), 64'd1);

    run_txn(1'b1, 12'h004, 3'd2, 4'hF, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    run_txn(1'b0, 12'h004, 3'd2, 4'hF, 32'h0, 0, 0, 1'b0, 0);
    run_txn(1'b0, 12'h004, 3'd2, 4'hF, 32'h0, 2, 1, 1'b0, 0);
    run_txn(1'b0, 12'h002, 3'd2, 4'hF, 32'h0, 0, 0, 1'b0, 0);
    run_txn(1'b0, 12'h004, 3'd2, 4'hF, 32'h0, 0, 1, 1'b1, 3);
    idle_cycles(1);

    // Reset asserted mid data phase of a write: no response may follow.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h008; cmd_size = 3'd2;
    cmd_strb = 4'hF; cmd_wdata = 32'hA5A5_5A5A;
    tick();
    cmd_valid = 1'b0; hready = 1'b1;
    tick();
    check("rst_in_data_hwdata", 64'(hwdata), 64'hA5A5_5A5A);
    hready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    last_hwdata = '0;
    tick();
    check_reset_outputs("held_reset");
    hready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rerelease_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("rerelease_first_clk_ready", 64'(cmd_ready), 64'd1);
    check("rerelease_no_rsp", 64'(rsp_valid), 64'd0);
    idle_cycles(2);

    for (int n = 0; n < 120; n++) begin
      wr   = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      addr = AW'($urandom_range(0, 63));
      err  = ($urandom_range(0, 4) == 0);
      wd   = $urandom_range(0, 2);
      if (err && wd == 0) wd = 1;
      run_txn(wr, addr, size, 4'($urandom), $urandom, $urandom_range(0, 2), wd, err,
              $urandom_range(0, 2));
      idle_cycles($urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
